// File: rtl/inst_encoder_pkg.sv
// Shared RV32I encoding definitions: opcodes, request codes, formats and per-op field lookup.
package inst_encoder_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned NUM_OPS = 37;

    localparam logic [6:0] R_OP       = 7'b0110011;
    localparam logic [6:0] I_MEM_OP   = 7'b0000011;
    localparam logic [6:0] I_LOGIC_OP = 7'b0010011;
    localparam logic [6:0] I_JALR_OP  = 7'b1100111;
    localparam logic [6:0] S_OP       = 7'b0100011;
    localparam logic [6:0] B_OP       = 7'b1100011;
    localparam logic [6:0] U_LUI_OP   = 7'b0110111;
    localparam logic [6:0] U_AUIPC_OP = 7'b0010111;
    localparam logic [6:0] J_OP       = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE
    } state_e;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 6'd0, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_JALR,
        OP_SB, OP_SH, OP_SW,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LUI, OP_AUIPC, OP_JAL
    } op_e;

    typedef struct packed {
        fmt_e       fmt;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } op_info_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [XLEN-1:0]  imm;
    } req_t;

    // Format and fixed fields for each request code; unknown codes fall back to an R-type add.
    function automatic op_info_t op_info(input logic [OP_W-1:0] op);
        op_info_t info;
        info = '{FMT_R, R_OP, 3'd0, 7'h00};
        case (op)
            OP_ADD:   info = '{FMT_R,  R_OP,       3'd0, 7'h00};
            OP_SUB:   info = '{FMT_R,  R_OP,       3'd0, 7'h20};
            OP_SLL:   info = '{FMT_R,  R_OP,       3'd1, 7'h00};
            OP_SLT:   info = '{FMT_R,  R_OP,       3'd2, 7'h00};
            OP_SLTU:  info = '{FMT_R,  R_OP,       3'd3, 7'h00};
            OP_XOR:   info = '{FMT_R,  R_OP,       3'd4, 7'h00};
            OP_SRL:   info = '{FMT_R,  R_OP,       3'd5, 7'h00};
            OP_SRA:   info = '{FMT_R,  R_OP,       3'd5, 7'h20};
            OP_OR:    info = '{FMT_R,  R_OP,       3'd6, 7'h00};
            OP_AND:   info = '{FMT_R,  R_OP,       3'd7, 7'h00};
            OP_LB:    info = '{FMT_I,  I_MEM_OP,   3'd0, 7'h00};
            OP_LH:    info = '{FMT_I,  I_MEM_OP,   3'd1, 7'h00};
            OP_LW:    info = '{FMT_I,  I_MEM_OP,   3'd2, 7'h00};
            OP_LBU:   info = '{FMT_I,  I_MEM_OP,   3'd4, 7'h00};
            OP_LHU:   info = '{FMT_I,  I_MEM_OP,   3'd5, 7'h00};
            OP_ADDI:  info = '{FMT_I,  I_LOGIC_OP, 3'd0, 7'h00};
            OP_SLTI:  info = '{FMT_I,  I_LOGIC_OP, 3'd2, 7'h00};
            OP_SLTIU: info = '{FMT_I,  I_LOGIC_OP, 3'd3, 7'h00};
            OP_XORI:  info = '{FMT_I,  I_LOGIC_OP, 3'd4, 7'h00};
            OP_ORI:   info = '{FMT_I,  I_LOGIC_OP, 3'd6, 7'h00};
            OP_ANDI:  info = '{FMT_I,  I_LOGIC_OP, 3'd7, 7'h00};
            OP_SLLI:  info = '{FMT_SH, I_LOGIC_OP, 3'd1, 7'h00};
            OP_SRLI:  info = '{FMT_SH, I_LOGIC_OP, 3'd5, 7'h00};
            OP_SRAI:  info = '{FMT_SH, I_LOGIC_OP, 3'd5, 7'h20};
            OP_JALR:  info = '{FMT_I,  I_JALR_OP,  3'd0, 7'h00};
            OP_SB:    info = '{FMT_S,  S_OP,       3'd0, 7'h00};
            OP_SH:    info = '{FMT_S,  S_OP,       3'd1, 7'h00};
            OP_SW:    info = '{FMT_S,  S_OP,       3'd2, 7'h00};
            OP_BEQ:   info = '{FMT_B,  B_OP,       3'd0, 7'h00};
            OP_BNE:   info = '{FMT_B,  B_OP,       3'd1, 7'h00};
            OP_BLT:   info = '{FMT_B,  B_OP,       3'd4, 7'h00};
            OP_BGE:   info = '{FMT_B,  B_OP,       3'd5, 7'h00};
            OP_BLTU:  info = '{FMT_B,  B_OP,       3'd6, 7'h00};
            OP_BGEU:  info = '{FMT_B,  B_OP,       3'd7, 7'h00};
            OP_LUI:   info = '{FMT_U,  U_LUI_OP,   3'd0, 7'h00};
            OP_AUIPC: info = '{FMT_U,  U_AUIPC_OP, 3'd0, 7'h00};
            OP_JAL:   info = '{FMT_J,  J_OP,       3'd0, 7'h00};
            default:  info = '{FMT_R,  R_OP,       3'd0, 7'h00};
        endcase
        return info;
    endfunction

    // Signed range checks reduce to "upper bits are a pure sign extension".
    function automatic logic imm_ok(input fmt_e fmt, input logic [XLEN-1:0] imm);
        logic ok;
        case (fmt)
            FMT_I, FMT_S: ok = (&imm[31:11]) | ~(|imm[31:11]);
            FMT_B:        ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
            FMT_J:        ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
            FMT_U:        ok = ~(|imm[11:0]);
            FMT_SH:       ok = ~(|imm[31:5]);
            default:      ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I packer: format plus fields to a 32-bit instruction word.
module inst_pack
    import inst_encoder_pkg::*;
(
    input  fmt_e             fmt_i,
    input  logic [6:0]       opcode_i,
    input  logic [2:0]       funct3_i,
    input  logic [6:0]       funct7_i,
    input  logic [REG_W-1:0] rd_i,
    input  logic [REG_W-1:0] rs1_i,
    input  logic [REG_W-1:0] rs2_i,
    input  logic [XLEN-1:0]  imm_i,
    output logic [XLEN-1:0]  inst_o
);

    always_comb begin
        inst_o = '0;
        case (fmt_i)
            FMT_R:  inst_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            FMT_I:  inst_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            FMT_SH: inst_o = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
            FMT_S:  inst_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            FMT_B:  inst_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                              imm_i[4:1], imm_i[11], opcode_i};
            FMT_U:  inst_o = {imm_i[31:12], rd_i, opcode_i};
            FMT_J:  inst_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            default: inst_o = '0;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I encoder: check stage, pack stage, sequential word addressing and program FSM.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned BASE   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic              done
);

    state_e            state_q, state_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_bad_q, s1_bad_d;
    fmt_e              s1_fmt_q, s1_fmt_d;
    req_t              s1_req_q, s1_req_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_inst_q, out_inst_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    op_info_t          in_info, s2_info;
    logic              in_bad;
    logic [XLEN-1:0]   pack_word;
    logic              out_hs, s2_free, s1_good_move, s1_drop, s1_free, accept, pipe_empty_next;

    assign in_info = op_info(in_op);
    assign in_bad  = (in_op > OP_W'(NUM_OPS - 1)) || !imm_ok(in_info.fmt, in_imm);
    assign s2_info = op_info(s1_req_q.op);

    // Rejected entries leave stage 1 unconditionally; good ones need room in stage 2.
    assign out_hs          = out_valid_q && out_ready;
    assign s2_free         = !out_valid_q || out_ready;
    assign s1_good_move    = s1_valid_q && !s1_bad_q && s2_free;
    assign s1_drop         = s1_valid_q && s1_bad_q;
    assign s1_free         = !s1_valid_q || s1_good_move || s1_drop;
    assign in_ready        = (state_q == ST_RUN) && s1_free;
    assign accept          = in_valid && in_ready;
    assign pipe_empty_next = (!s1_valid_q || s1_drop) && s2_free;

    inst_pack u_pack (
        .fmt_i    (s1_fmt_q),
        .opcode_i (s2_info.opcode),
        .funct3_i (s2_info.funct3),
        .funct7_i (s2_info.funct7),
        .rd_i     (s1_req_q.rd),
        .rs1_i    (s1_req_q.rs1),
        .rs2_i    (s1_req_q.rs2),
        .imm_i    (s1_req_q.imm),
        .inst_o   (pack_word)
    );

    always_comb begin
        state_d     = state_q;
        s1_valid_d  = s1_valid_q;
        s1_bad_d    = s1_bad_q;
        s1_fmt_d    = s1_fmt_q;
        s1_req_d    = s1_req_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_addr_d  = out_addr_q;
        err_d       = err_q;
        done_d      = 1'b0;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_bad_d   = in_bad;
            s1_fmt_d   = in_info.fmt;
            s1_req_d   = '{op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
        end else if (s1_good_move || s1_drop) begin
            s1_valid_d = 1'b0;
        end

        if (s1_good_move) begin
            out_valid_d = 1'b1;
            out_inst_d  = pack_word;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end

        if (out_hs) begin
            out_addr_d = out_addr_q + ADDR_W'(1);
        end
        if (s1_drop) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    out_addr_d = ADDR_W'(BASE);
                    err_d      = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept && in_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Only requests up to the last one remain, so empty means complete.
                if (pipe_empty_next) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_bad_q    <= 1'b0;
            s1_fmt_q    <= FMT_R;
            s1_req_q    <= '0;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_addr_q  <= ADDR_W'(BASE);
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_bad_q    <= s1_bad_d;
            s1_fmt_q    <= s1_fmt_d;
            s1_req_q    <= s1_req_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_addr_q  <= out_addr_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_addr  = out_addr_q;
    assign err       = err_q;
    assign done      = done_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder with hand-assembled expected RV32I words.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst, start, in_valid, in_ready, in_last;
    logic [5:0]        in_op;
    logic [4:0]        in_rd, in_rs1, in_rs2;
    logic [31:0]       in_imm;
    logic              out_valid, out_ready, err, done;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;

    always #5 clk = ~clk;

    inst_encoder #(.ADDR_W(ADDR_W), .BASE(0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
        .err(err), .done(done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [31:0]       got_inst[$];
    logic [ADDR_W-1:0] got_addr[$];
    int                got_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bench inputs only change on the falling edge, so sampling 3 units later is stable.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (out_valid && out_ready) begin
                got_inst.push_back(out_inst);
                got_addr.push_back(out_addr);
                got_cyc.push_back(cyc);
            end
        end
    end

    task automatic clear_log();
        got_inst.delete();
        got_addr.delete();
        got_cyc.delete();
    endtask

    task automatic start_prog();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic last);
        bit acc = 0;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            #3;
            if (in_ready) begin
                acc = 1;
                @(posedge clk);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) check("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic check_word(input string tag, input int idx, input logic [31:0] exp_inst,
                              input logic [ADDR_W-1:0] exp_addr);
        if (idx < got_inst.size()) begin
            check({tag, "_inst"}, got_inst[idx], exp_inst);
            check({tag, "_addr"}, 32'(got_addr[idx]), 32'(exp_addr));
        end else begin
            check({tag, "_missing"}, 32'(got_inst.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_op = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // addi x1,x0,5: latency and done timing
        clear_log();
        start_prog();
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        check("t1_n1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t1_n2_valid", 32'(out_valid), 32'd1);
        check("t1_inst", out_inst, 32'h00500093);
        check("t1_addr", 32'(out_addr), 32'd0);
        check("t1_done_early", 32'(done), 32'd0);
        @(negedge clk);
        check("t1_done", 32'(done), 32'd1);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'd0);

        // back-to-back R / S / B
        clear_log();
        start_prog();
        send(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        send(OP_SW,  5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        send(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1);
        wait_done("t2_done");
        check("t2_count", 32'(got_inst.size()), 32'd3);
        check_word("t2_w0", 0, 32'h002081B3, 10'd0);
        check_word("t2_w1", 1, 32'h0020A423, 10'd1);
        check_word("t2_w2", 2, 32'hFE208EE3, 10'd2);
        if (got_cyc.size() == 3) begin
            check("t2_gap01", 32'(got_cyc[1] - got_cyc[0]), 32'd1);
            check("t2_gap12", 32'(got_cyc[2] - got_cyc[1]), 32'd1);
        end

        // U-type, including a rejected low-bits immediate
        clear_log();
        start_prog();
        send(OP_LUI,   5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0);
        send(OP_LUI,   5'd5, 5'd0, 5'd0, 32'h1234_5001, 1'b0);
        send(OP_AUIPC, 5'd2, 5'd0, 5'd0, 32'h0000_1000, 1'b1);
        wait_done("t3_done");
        check("t3_count", 32'(got_inst.size()), 32'd2);
        check_word("t3_w0", 0, 32'h123452B7, 10'd0);
        check_word("t3_w1", 1, 32'h00001117, 10'd1);
        check("t3_err", 32'(err), 32'd1);

        // rejections and immediate boundaries
        clear_log();
        start_prog();
        check("t4_err_cleared", 32'(err), 32'd0);
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
        send(6'd40,   5'd1, 5'd0, 5'd0, 32'd0, 1'b0);
        send(OP_BEQ,  5'd0, 5'd0, 5'd0, 32'd3, 1'b0);
        send(OP_SLLI, 5'd1, 5'd1, 5'd0, 32'd32, 1'b0);
        send(OP_JAL,  5'd1, 5'd0, 5'd0, 32'h0010_0000, 1'b0);
        repeat (3) @(negedge clk);
        check("t4_no_word", 32'(got_inst.size()), 32'd0);
        check("t4_err_set", 32'(err), 32'd1);
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 1'b0);
        send(OP_BEQ,  5'd0, 5'd0, 5'd0, 32'd4094, 1'b0);
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        wait_done("t4_done");
        check("t4_count", 32'(got_inst.size()), 32'd3);
        check_word("t4_w0", 0, 32'h80000093, 10'd0);
        check_word("t4_w1", 1, 32'h7E000FE3, 10'd1);
        check_word("t4_w2", 2, 32'h00500093, 10'd2);
        check("t4_err_sticky", 32'(err), 32'd1);

        // backpressure during a 6-instruction stream
        clear_log();
        start_prog();
        out_ready = 1'b0;
        fork
            begin
                send(OP_SUB,  5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
                send(OP_SRAI, 5'd1, 5'd2, 5'd0, 32'd3, 1'b0);
                send(OP_JAL,  5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
                send(OP_JALR, 5'd1, 5'd2, 5'd0, 32'd0, 1'b0);
                send(OP_LW,   5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF, 1'b0);
                send(OP_LUI,  5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1);
            end
            begin
                repeat (2) @(negedge clk);
                #3;
                check("t5_hold_a_valid", 32'(out_valid), 32'd1);
                check("t5_hold_a_inst", out_inst, 32'h402081B3);
                check("t5_hold_a_addr", 32'(out_addr), 32'd0);
                repeat (3) @(negedge clk);
                #3;
                check("t5_hold_b_inst", out_inst, 32'h402081B3);
                check("t5_hold_b_addr", 32'(out_addr), 32'd0);
                check("t5_in_ready_low", 32'(in_ready), 32'd0);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_done("t5_done");
        check("t5_count", 32'(got_inst.size()), 32'd6);
        check_word("t5_w0", 0, 32'h402081B3, 10'd0);
        check_word("t5_w1", 1, 32'h40315093, 10'd1);
        check_word("t5_w2", 2, 32'h001000EF, 10'd2);
        check_word("t5_w3", 3, 32'h000100E7, 10'd3);
        check_word("t5_w4", 4, 32'hFFF32283, 10'd4);
        check_word("t5_w5", 5, 32'h123452B7, 10'd5);

        // reset with two requests in flight
        clear_log();
        start_prog();
        out_ready = 1'b0;
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        send(OP_ADD,  5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_out_addr", 32'(out_addr), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd0);
        check("t6_err", 32'(err), 32'd0);
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_no_word", 32'(got_inst.size()), 32'd0);
        check("t6_idle", 32'(in_ready), 32'd0);
        check("t6_done", 32'(done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
